// File: rtl/pc_unit_pkg.sv
// Shared control definitions for the fetch side: PC unit state encoding
// and the sequential instruction step.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int PC_INCREMENT = 4;

endpackage

// File: rtl/pc_unit_next_adder.sv
// Combinational next-PC selection: branch target (PC + offset) or sequential
// step, both wrapping naturally at the PC width.
module pc_next_adder
    import pc_unit_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic [ADDRESS_WIDTH-1:0] pc,
    input  logic                     pcsrc,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    output logic [ADDRESS_WIDTH-1:0] next_pc
);

    always_comb begin
        if (pcsrc) begin
            next_pc = pc + offset;
        end else begin
            next_pc = pc + ADDRESS_WIDTH'(PC_INCREMENT);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter unit: BOOT/RUN/HALT sequencing, PC update and retired-advance
// counting. Branch-to-self halt detection is built only with PC_HALT_DETECT_EN.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int RESET_PC      = 0,
    parameter int HALT_COUNT    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PCsrc,
    input  logic [DATA_WIDTH-1:0]    ImmOp,
    input  logic                     fetch_ready,
    output logic [ADDRESS_WIDTH-1:0] PC,
    output logic                     pc_valid,
    output logic                     halted,
    output logic [DATA_WIDTH-1:0]    instr_count
);

    pc_state_t                state;
    pc_state_t                state_next;
    logic                     advance;
    logic [ADDRESS_WIDTH-1:0] next_pc;

    // Only the low PC-width bits of the offset can affect a wrapping PC.
    logic unused_imm_hi;
    assign unused_imm_hi = ^ImmOp[DATA_WIDTH-1:ADDRESS_WIDTH];

    pc_next_adder #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_next_adder (
        .pc     (PC),
        .pcsrc  (PCsrc),
        .offset (ImmOp[ADDRESS_WIDTH-1:0]),
        .next_pc(next_pc)
    );

`ifdef PC_HALT_DETECT_EN
    localparam int CW = $clog2(HALT_COUNT + 1);
    localparam logic [CW-1:0] SELF_LAST = CW'(HALT_COUNT - 1);

    logic [CW-1:0] self_cnt;
    logic          self_hit;

    assign self_hit = PCsrc && (ImmOp[ADDRESS_WIDTH-1:0] == '0);
    assign halted   = (state == HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            self_cnt <= '0;
        end else if (advance) begin
            self_cnt <= self_hit ? self_cnt + CW'(1) : '0;
        end
    end
`else
    localparam int unused_halt_count = HALT_COUNT;
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            PC          <= ADDRESS_WIDTH'(RESET_PC);
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (advance) begin
                PC <= next_pc;
                if (instr_count != '1) begin
                    instr_count <= instr_count + DATA_WIDTH'(1);
                end
            end
        end
    end

    // An advance happens only while a live PC is offered and accepted.
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        pc_valid   = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                pc_valid = 1'b1;
                advance  = fetch_ready;
`ifdef PC_HALT_DETECT_EN
                if (fetch_ready && self_hit && (self_cnt == SELF_LAST)) begin
                    state_next = HALT;
                end
`endif
            end
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, hand-written halt and
// reset sequences, then randomized traffic against a behavioural model.
module tb_pc_unit;

    localparam int HALT_COUNT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCsrc = 1'b0;
    logic [31:0] ImmOp = '0;
    logic        fetch_ready = 1'b0;
    logic [7:0]  PC;
    logic        pc_valid;
    logic        halted;
    logic [31:0] instr_count;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: plain integers following the written rules.
    int     m_pc;
    longint m_count;
    int     m_self;
    bit     m_booted;
    bit     m_halted;

    typedef struct {
        logic        rst;
        logic        fr;
        logic        src;
        logic [31:0] imm;
        logic [7:0]  pc;
        logic        valid;
        logic        halt;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];

    pc_unit dut (
        .clk        (clk),
        .rst        (rst),
        .PCsrc      (PCsrc),
        .ImmOp      (ImmOp),
        .fetch_ready(fetch_ready),
        .PC         (PC),
        .pc_valid   (pc_valid),
        .halted     (halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic modelStep(input logic r, input logic f, input logic s, input logic [31:0] imm);
        if (r) begin
            m_pc = 0; m_count = 0; m_self = 0; m_booted = 0; m_halted = 0;
        end else if (!m_booted) begin
            m_booted = 1;
        end else if (!m_halted && f) begin
            m_pc = (m_pc + (s ? int'(imm & 32'hFF) : 4)) % 256;
            if (m_count < 64'hFFFF_FFFF) m_count++;
`ifdef PC_HALT_DETECT_EN
            if (s && (imm & 32'hFF) == 0) m_self++;
            else m_self = 0;
            if (m_self == HALT_COUNT) m_halted = 1;
`endif
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic s, input logic [31:0] imm);
        rst = r; fetch_ready = f; PCsrc = s; ImmOp = imm;
        @(posedge clk);
        modelStep(r, f, s, imm);
        #1;
    endtask

    task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".pc"},     64'(PC),          64'(m_pc));
        checkValue({tag, ".valid"},  64'(pc_valid),    64'(m_booted && !m_halted));
        checkValue({tag, ".halted"}, 64'(halted),      64'(m_halted));
        checkValue({tag, ".count"},  64'(instr_count), 64'(m_count));
    endtask

    function automatic void addVec(input logic r, input logic f, input logic s, input logic [31:0] imm,
                                   input logic [7:0] pc, input logic v, input logic [31:0] cnt);
        vec_t e;
        e.rst = r; e.fr = f; e.src = s; e.imm = imm;
        e.pc = pc; e.valid = v; e.halt = 1'b0; e.cnt = cnt;
        tbl.push_back(e);
    endfunction

    initial begin
        // Reset release, sequential steps, branches, wrap and stall.
        addVec(1'b1, 1'b1, 1'b0, 32'h0,        8'h00, 1'b0, 32'd0);
        addVec(1'b0, 1'b1, 1'b0, 32'h0,        8'h00, 1'b1, 32'd0);
        addVec(1'b0, 1'b1, 1'b0, 32'h0,        8'h04, 1'b1, 32'd1);
        addVec(1'b0, 1'b1, 1'b0, 32'h0,        8'h08, 1'b1, 32'd2);
        addVec(1'b0, 1'b1, 1'b0, 32'h0,        8'h0C, 1'b1, 32'd3);
        addVec(1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 8'h08, 1'b1, 32'd4);
        addVec(1'b0, 1'b1, 1'b1, 32'hFFFFFFF8, 8'h00, 1'b1, 32'd5);
        addVec(1'b0, 1'b1, 1'b0, 32'h0,        8'h04, 1'b1, 32'd6);
        addVec(1'b0, 1'b1, 1'b0, 32'h0,        8'h08, 1'b1, 32'd7);
        addVec(1'b0, 1'b1, 1'b1, 32'h10,       8'h18, 1'b1, 32'd8);
        addVec(1'b0, 1'b1, 1'b1, 32'hD8,       8'hF0, 1'b1, 32'd9);
        addVec(1'b0, 1'b1, 1'b0, 32'h0,        8'hF4, 1'b1, 32'd10);
        addVec(1'b0, 1'b1, 1'b0, 32'h0,        8'hF8, 1'b1, 32'd11);
        addVec(1'b0, 1'b1, 1'b0, 32'h0,        8'hFC, 1'b1, 32'd12);
        addVec(1'b0, 1'b1, 1'b0, 32'h0,        8'h00, 1'b1, 32'd13);
        addVec(1'b0, 1'b0, 1'b1, 32'h40,       8'h00, 1'b1, 32'd13);
        addVec(1'b0, 1'b0, 1'b0, 32'h40,       8'h00, 1'b1, 32'd13);
        addVec(1'b0, 1'b0, 1'b1, 32'h0,        8'h00, 1'b1, 32'd13);
        addVec(1'b0, 1'b1, 1'b0, 32'h40,       8'h04, 1'b1, 32'd14);

        #2;
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].rst, tbl[i].fr, tbl[i].src, tbl[i].imm);
            checkValue($sformatf("vec%0d.pc", i),     64'(PC),          64'(tbl[i].pc));
            checkValue($sformatf("vec%0d.valid", i),  64'(pc_valid),    64'(tbl[i].valid));
            checkValue($sformatf("vec%0d.halted", i), 64'(halted),      64'(tbl[i].halt));
            checkValue($sformatf("vec%0d.count", i),  64'(instr_count), 64'(tbl[i].cnt));
        end

        // Branch-to-self at PC 20, then reset while stuck there.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkValue("pre_self.pc", 64'(PC), 64'd20);
        for (int i = 0; i < HALT_COUNT; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'h0);
            checkOutput($sformatf("self%0d", i));
        end
`ifdef PC_HALT_DETECT_EN
        checkValue("halt.halted", 64'(halted),      64'd1);
        checkValue("halt.valid",  64'(pc_valid),    64'd0);
        checkValue("halt.pc",     64'(PC),          64'd20);
        checkValue("halt.count",  64'(instr_count), 64'd9);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkValue("halt_hold.pc",    64'(PC),          64'd20);
        checkValue("halt_hold.count", 64'(instr_count), 64'd9);
`else
        checkValue("nohalt.halted", 64'(halted), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0);
        checkValue("nohalt.pc",    64'(PC),          64'd20);
        checkValue("nohalt.count", 64'(instr_count), 64'd11);
        checkValue("nohalt.valid", 64'(pc_valid),    64'd1);
`endif
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0);
        checkValue("rst_mid.pc",     64'(PC),          64'd0);
        checkValue("rst_mid.halted", 64'(halted),      64'd0);
        checkValue("rst_mid.count",  64'(instr_count), 64'd0);
        checkValue("rst_mid.valid",  64'(pc_valid),    64'd0);

        // Randomized traffic with occasional resets and frequent self-branches.
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic        f;
            logic        s;
            logic [31:0] imm;
            r = ($urandom_range(0, 39) == 0);
            f = ($urandom_range(0, 9) < 7);
            s = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       imm = 32'h0;
                1:       imm = $urandom;
                2:       imm = {24'hFFFFFF, 8'($urandom_range(0, 255))};
                default: imm = {24'($urandom), 8'h00};
            endcase
            applyStimulus(r, f, s, imm);
            checkOutput($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
